video_timing_ctrl: RTL

Programmable raster timing controller for the HDMI output path. Generates the `vs`/`hs`/`de` strobes and active-pixel coordinates that feed the pattern/overlay pixel stage, sequences start/stop on frame boundaries, and accepts runtime resolution changes through a valid/ready handshake. New timings take effect only at a frame boundary, so the downstream pixel stage never sees a torn frame.

---
 rtl/video_timing_pkg.sv | 51 +++++
 rtl/video_timing_ctrl_raster_counter.sv | 43 ++++
 rtl/video_timing_ctrl.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared definitions for the raster timing controller.
//   timing_t       : one complete timing set, 8 x 12-bit fields (pixels / lines)
//   state_t        : run-control FSM encoding
//   TIMING_720P60  : timing loaded by reset (1280x720p60)
//   line_total()   : sync + bp + act + fp at 14 bits (cannot wrap for 12-bit fields)
//   timing_ok()    : a set is usable only with non-zero act and sync in both axes
package video_timing_pkg;

  localparam int unsigned CFG_W = 12;
  localparam int unsigned TOT_W = 14;

  typedef struct packed {
    logic [CFG_W-1:0] h_act;
    logic [CFG_W-1:0] h_fp;
    logic [CFG_W-1:0] h_sync;
    logic [CFG_W-1:0] h_bp;
    logic [CFG_W-1:0] v_act;
    logic [CFG_W-1:0] v_fp;
    logic [CFG_W-1:0] v_sync;
    logic [CFG_W-1:0] v_bp;
  } timing_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam timing_t TIMING_720P60 = '{
    h_act:  12'd1280,
    h_fp:   12'd110,
    h_sync: 12'd40,
    h_bp:   12'd220,
    v_act:  12'd720,
    v_fp:   12'd5,
    v_sync: 12'd5,
    v_bp:   12'd20
  };

  function automatic logic [TOT_W-1:0] line_total(input logic [CFG_W-1:0] sync,
                                                   input logic [CFG_W-1:0] bp,
                                                   input logic [CFG_W-1:0] act,
                                                   input logic [CFG_W-1:0] fp);
    return TOT_W'(sync) + TOT_W'(bp) + TOT_W'(act) + TOT_W'(fp);
  endfunction

  function automatic logic timing_ok(input timing_t t);
    return (t.h_act != '0) && (t.v_act != '0) && (t.h_sync != '0) && (t.v_sync != '0);
  endfunction

endpackage

// File: rtl/video_timing_ctrl_raster_counter.sv
// raster_counter: horizontal/vertical position counters for the raster.
//   pix_clk, rstn       : pixel clock, async active-low reset
//   run                 : advance when 1, hold both counters at 0 when 0
//   h_total, v_total    : frame geometry from the active timing set
//   h_cnt, v_cnt        : current position, line order sync/bp/act/fp
//   frame_end           : counters sit on the last pixel of the frame
module raster_counter
  import video_timing_pkg::*;
#(
  parameter int unsigned X_BITS = 13,
  parameter int unsigned Y_BITS = 13
) (
  input  logic              pix_clk,
  input  logic              rstn,
  input  logic              run,
  input  logic [TOT_W-1:0]  h_total,
  input  logic [TOT_W-1:0]  v_total,
  output logic [X_BITS-1:0] h_cnt,
  output logic [Y_BITS-1:0] v_cnt,
  output logic              frame_end
);

  logic line_end;

  assign line_end  = (TOT_W'(h_cnt) == (h_total - TOT_W'(1)));
  assign frame_end = line_end && (TOT_W'(v_cnt) == (v_total - TOT_W'(1)));

  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (!run) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (line_end) begin
      h_cnt <= '0;
      v_cnt <= frame_end ? '0 : v_cnt + Y_BITS'(1);
    end else begin
      h_cnt <= h_cnt + X_BITS'(1);
    end
  end

endmodule

// File: rtl/video_timing_ctrl.sv
// video_timing_ctrl: programmable raster timing generator for the HDMI path.
//   pix_clk, rstn            : pixel clock, async active-low reset
//   en                       : run request; a stop only takes effect at frame end
//   cfg_valid/cfg_ready      : handshake for a new timing set (cfg_h_*, cfg_v_*)
//   cfg_err                  : one-cycle pulse when an accepted set is unusable
//   vs_out, hs_out, de_out   : raster strobes (sync polarity set by VS_POL/HS_POL)
//   act_x, act_y             : active-area coordinates, 0 outside de_out
//   frame_start              : pulse on the first output cycle of each frame
//   busy                     : frame output in progress
// A new set waits in a shadow slot and is promoted to the active set only at a
// frame boundary (or straight away while idle), so no frame mixes two timings.
module video_timing_ctrl
  import video_timing_pkg::*;
#(
  parameter int unsigned X_BITS = 13,
  parameter int unsigned Y_BITS = 13,
  parameter bit          HS_POL = 1'b1,
  parameter bit          VS_POL = 1'b1
) (
  input  logic              pix_clk,
  input  logic              rstn,
  input  logic              en,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [11:0]       cfg_h_act,
  input  logic [11:0]       cfg_h_fp,
  input  logic [11:0]       cfg_h_sync,
  input  logic [11:0]       cfg_h_bp,
  input  logic [11:0]       cfg_v_act,
  input  logic [11:0]       cfg_v_fp,
  input  logic [11:0]       cfg_v_sync,
  input  logic [11:0]       cfg_v_bp,
  output logic              cfg_err,
  output logic              vs_out,
  output logic              hs_out,
  output logic              de_out,
  output logic [X_BITS-1:0] act_x,
  output logic [Y_BITS-1:0] act_y,
  output logic              frame_start,
  output logic              busy
);

  state_t            state, state_nx;
  timing_t           act_tm, shd_tm, cfg_tm;
  logic              shd_full;
  logic              run, frame_last, cfg_take, cfg_good, shd_copy;
  logic [TOT_W-1:0]  h_total, v_total;
  logic [X_BITS-1:0] h_cnt;
  logic [Y_BITS-1:0] v_cnt;
  logic              frame_end;

  assign cfg_tm = '{
    h_act:  cfg_h_act,
    h_fp:   cfg_h_fp,
    h_sync: cfg_h_sync,
    h_bp:   cfg_h_bp,
    v_act:  cfg_v_act,
    v_fp:   cfg_v_fp,
    v_sync: cfg_v_sync,
    v_bp:   cfg_v_bp
  };

  assign h_total = line_total(act_tm.h_sync, act_tm.h_bp, act_tm.h_act, act_tm.h_fp);
  assign v_total = line_total(act_tm.v_sync, act_tm.v_bp, act_tm.v_act, act_tm.v_fp);

  // ---- run-control FSM ----
  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // DRAIN is RUN with the stop remembered; raising en again cancels it.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE:  if (en) state_nx = ST_RUN;
      ST_RUN: begin
        if (frame_end && !en) state_nx = ST_IDLE;
        else if (!en)         state_nx = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (frame_end && !en) state_nx = ST_IDLE;
        else if (en)          state_nx = ST_RUN;
      end
      default:                state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    run        = (state != ST_IDLE);
    frame_last = run && frame_end;
    shd_copy   = shd_full && (frame_last || (state == ST_IDLE));
  end

  // ---- config handshake / shadow slot ----
  assign cfg_ready = ~shd_full;
  assign cfg_take  = cfg_valid && cfg_ready;
  assign cfg_good  = timing_ok(cfg_tm);

  // take and copy are exclusive: take needs an empty slot, copy a full one
  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      shd_full <= 1'b0;
      cfg_err  <= 1'b0;
      act_tm   <= TIMING_720P60;
    end else begin
      cfg_err <= cfg_take && !cfg_good;
      if (shd_copy) begin
        act_tm   <= shd_tm;
        shd_full <= 1'b0;
      end else if (cfg_take && cfg_good) begin
        shd_full <= 1'b1;
      end
    end
  end

  // slot contents are qualified by shd_full, so they need no reset
  always_ff @(posedge pix_clk) begin
    if (cfg_take) shd_tm <= cfg_tm;
  end

  raster_counter #(
    .X_BITS (X_BITS),
    .Y_BITS (Y_BITS)
  ) u_raster (
    .pix_clk   (pix_clk),
    .rstn      (rstn),
    .run       (run),
    .h_total   (h_total),
    .v_total   (v_total),
    .h_cnt     (h_cnt),
    .v_cnt     (v_cnt),
    .frame_end (frame_end)
  );

  // ---- stage p0: decode of counter position ----
  logic [TOT_W-1:0]  hc_p0, vc_p0, h_beg, h_end, v_beg, v_end;
  logic              hs_p0, vs_p0, de_p0, fs_p0, vld_p0;
  logic [X_BITS-1:0] x_p0;
  logic [Y_BITS-1:0] y_p0;

  assign hc_p0  = TOT_W'(h_cnt);
  assign vc_p0  = TOT_W'(v_cnt);
  assign h_beg  = TOT_W'(act_tm.h_sync) + TOT_W'(act_tm.h_bp);
  assign h_end  = h_beg + TOT_W'(act_tm.h_act);
  assign v_beg  = TOT_W'(act_tm.v_sync) + TOT_W'(act_tm.v_bp);
  assign v_end  = v_beg + TOT_W'(act_tm.v_act);
  assign vld_p0 = run;
  assign hs_p0  = vld_p0 && (hc_p0 < TOT_W'(act_tm.h_sync));
  assign vs_p0  = vld_p0 && (vc_p0 < TOT_W'(act_tm.v_sync));
  assign de_p0  = vld_p0 && (hc_p0 >= h_beg) && (hc_p0 < h_end)
                         && (vc_p0 >= v_beg) && (vc_p0 < v_end);
  assign x_p0   = de_p0 ? X_BITS'(hc_p0 - h_beg) : '0;
  assign y_p0   = de_p0 ? Y_BITS'(vc_p0 - v_beg) : '0;
  assign fs_p0  = vld_p0 && (h_cnt == '0) && (v_cnt == '0);

  // ---- stage p1: registered outputs ----
  always_ff @(posedge pix_clk or negedge rstn) begin
    if (!rstn) begin
      hs_out      <= ~HS_POL;
      vs_out      <= ~VS_POL;
      de_out      <= 1'b0;
      act_x       <= '0;
      act_y       <= '0;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      hs_out      <= hs_p0 ? HS_POL : ~HS_POL;
      vs_out      <= vs_p0 ? VS_POL : ~VS_POL;
      de_out      <= de_p0;
      act_x       <= x_p0;
      act_y       <= y_p0;
      frame_start <= fs_p0;
      busy        <= vld_p0;
    end
  end

endmodule
